i2s_audio_tx: RTL and testbench

//   Consumer end of the mixer's sample interface: accepts the 16-bit signed mixed

---
 rtl/audio_pkg.sv | 23 ++
 rtl/i2s_clkgen.sv | 54 +++++
 rtl/i2s_audio_tx.sv | 82 ++++++++
 tb/tb_i2s_audio_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and I2S framing defaults
//
// Purpose: common definitions for the mixer and the I2S transmitter.
//   SAMPLE_W   default sample width (two's complement)
//   SLOT_BITS  default BCLK periods per channel slot
//   BCLK_HALF  default CLK cycles per BCLK half-period
//   sample_t   signed mixed-sample type
//   is_data_bit(k, w)  true when slot bit position k carries sample data
package audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int SLOT_BITS = 32;
  localparam int BCLK_HALF = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Philips I2S: position 0 of each slot is the one-bit delay after the LRCK
  // edge, positions 1..w carry the sample MSB first, the rest is padding.
  function automatic logic is_data_bit(input int k, input int w);
    return (k >= 1) && (k <= w);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK divider, falling-edge strobe, bit counter and LRCK
//
// Purpose: derives the I2S bit clock and word select from the system clock.
// Ports:
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   bclk      out  bit clock, 50% duty, registered
//   lrck      out  word select, 0 = left, 1 = right, registered
//   fall_stb  out  high in the CLK cycle whose edge makes bclk fall
//   bit_next  out  bit counter value that takes effect on this fall_stb
module i2s_clkgen #(
  parameter int BCLK_HALF = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  output logic                           bclk,
  output logic                           lrck,
  output logic                           fall_stb,
  output logic [$clog2(2*SLOT_BITS)-1:0] bit_next
);

  localparam int DW = $clog2(BCLK_HALF);
  localparam int CW = $clog2(2*SLOT_BITS);

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] bit_cnt;
  logic          wrap;

  assign wrap     = (div_cnt == DW'(BCLK_HALF - 1));
  assign fall_stb = wrap && bclk;
  assign bit_next = (bit_cnt == CW'(2*SLOT_BITS - 1)) ? '0 : bit_cnt + CW'(1);

  // bit_cnt resets to the last position so the first fall lands on 0 and
  // starts a frame (and a capture) straight away.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= CW'(2*SLOT_BITS - 1);
      lrck    <= 1'b1;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DW'(1);
      if (wrap) begin
        bclk <= ~bclk;
      end
      if (fall_stb) begin
        bit_cnt <= bit_next;
        lrck    <= (bit_next >= CW'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - mono sample to Philips I2S transmitter with capture pacing
//
// Purpose: latches the mixed sample once per frame and shifts it out MSB first
//   in both the left and right slots.
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   synchronous active-high reset
//   sample_in   in   signed mixed sample, sampled only at capture
//   sound_on    in   any channel active, sampled at capture
//   i2s_bclk    out  bit clock
//   i2s_lrck    out  word select, 0 = left, 1 = right
//   i2s_sdata   out  serial data, MSB first
//   sample_req  out  one-CLK pulse in the cycle a sample is captured
//   dac_mute    out  ~sound_on as captured with the sample
module i2s_audio_tx #(
  parameter int BCLK_HALF = audio_pkg::BCLK_HALF,
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int SLOT_BITS = audio_pkg::SLOT_BITS
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sound_on,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata,
  output logic                       sample_req,
  output logic                       dac_mute
);

  import audio_pkg::*;

  localparam int CW = $clog2(2*SLOT_BITS);

  logic                       fall_stb;
  logic [CW-1:0]              n;
  logic [CW-1:0]              k;
  logic signed [SAMPLE_W-1:0] hold;
  logic [SAMPLE_W-1:0]        shifted;
  logic                       data_bit;

  i2s_clkgen #(
    .BCLK_HALF (BCLK_HALF),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .CLK      (CLK),
    .RST      (RST),
    .bclk     (i2s_bclk),
    .lrck     (i2s_lrck),
    .fall_stb (fall_stb),
    .bit_next (n)
  );

  // Slot position k selects hold bit SAMPLE_W-k; shifting left by k-1 puts
  // that bit at the MSB. The shift result is ignored outside 1..SAMPLE_W.
  always_comb begin
    k        = (n >= CW'(SLOT_BITS)) ? n - CW'(SLOT_BITS) : n;
    shifted  = $unsigned(hold) << (k - CW'(1));
    data_bit = is_data_bit(int'(k), SAMPLE_W) ? shifted[SAMPLE_W-1] : 1'b0;
  end

  // At n==0 the data bit is padding, so updating hold on the same strobe
  // never disturbs the bit being driven.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold       <= '0;
      i2s_sdata  <= 1'b0;
      sample_req <= 1'b0;
      dac_mute   <= 1'b1;
    end else begin
      sample_req <= fall_stb && (n == '0);
      if (fall_stb) begin
        i2s_sdata <= data_bit;
        if (n == '0) begin
          hold     <= sound_on ? sample_in : '0;
          dac_mute <= ~sound_on;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - self-checking bench for i2s_audio_tx
module tb_i2s_audio_tx;

  import audio_pkg::*;

  localparam int BH    = 2;
  localparam int SB    = 32;
  localparam int W     = 16;
  localparam int FRAME = 4 * BH * SB;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  sample_t sample_in;
  logic    sound_on;
  logic    i2s_bclk, i2s_lrck, i2s_sdata, sample_req, dac_mute;

  always #5 clk = ~clk;

  i2s_audio_tx #(
    .BCLK_HALF (BH),
    .SAMPLE_W  (W),
    .SLOT_BITS (SB)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .sample_in  (sample_in),
    .sound_on   (sound_on),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .sample_req (sample_req),
    .dac_mute   (dac_mute)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: CLK edges since reset release (c) and the value captured for the
  // current frame. Everything else follows from c by arithmetic.
  int          c       = 0;
  logic [15:0] m_frame = '0;
  logic        m_mute  = 1'b1;
  bit          chk_en  = 1'b0;

  function automatic bit is_capture(input int cc);
    return (cc >= 2*BH) && (((cc - 2*BH) % FRAME) == 0);
  endfunction

  always @(posedge clk) begin
    int nc;
    if (rst) begin
      c       <= 0;
      m_frame <= '0;
      m_mute  <= 1'b1;
    end else begin
      nc = c + 1;
      c <= nc;
      if (is_capture(nc)) begin
        m_frame <= sound_on ? sample_in : '0;
        m_mute  <= ~sound_on;
      end
    end
  end

  logic prev_bclk = 1'b0;
  int   run_len   = 0;
  bit   run_valid = 1'b0;

  always @(negedge clk) begin
    int m, n, k;
    logic e_bclk, e_lrck, e_sdata;
    logic [15:0] sh;
    if (chk_en) begin
      e_bclk = ((c / BH) % 2) == 1;
      m = c / (2*BH);
      e_lrck = 1'b1;
      e_sdata = 1'b0;
      if (m > 0) begin
        n = (m - 1) % (2*SB);
        e_lrck = (n >= SB);
        k = n % SB;
        if (k >= 1 && k <= W) begin
          sh = m_frame << (k - 1);
          e_sdata = sh[W-1];
        end
      end
      check("bclk",       32'(i2s_bclk),   32'(e_bclk));
      check("lrck",       32'(i2s_lrck),   32'(e_lrck));
      check("sdata",      32'(i2s_sdata),  32'(e_sdata));
      check("sample_req", 32'(sample_req), 32'(is_capture(c)));
      check("dac_mute",   32'(dac_mute),   32'(m_mute));
      // every high and low phase of bclk must last exactly BH CLKs
      if (c == 0) begin
        run_valid = 1'b0;
        run_len   = 0;
      end else if (i2s_bclk != prev_bclk) begin
        if (run_valid) check("bclk_phase_len", 32'(run_len), 32'(BH));
        run_valid = 1'b1;
        run_len   = 1;
      end else begin
        run_len++;
      end
      prev_bclk = i2s_bclk;
    end
  end

  task automatic wait_req();
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sample_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("sample_req_seen", 32'(ok), 32'd1);
  endtask

  task automatic cycles_to_req(input string name, input int exp);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!sample_req && cnt < 600);
    check(name, 32'(cnt), 32'(exp));
  endtask

  // I2S receiver: call on the negedge where sample_req is high; samples sdata
  // on 64 bclk rising edges. Optionally changes sample_in mid-frame.
  task automatic collect_frame(input int chg_at, input logic [15:0] chg_val,
                               output logic [31:0] left, output logic [31:0] right,
                               output int lr_err);
    int   rises = 0;
    int   iter  = 0;
    logic prev  = i2s_bclk;
    left = '0;
    right = '0;
    lr_err = 0;
    while (rises < 64 && iter < 400) begin
      @(negedge clk);
      iter++;
      if (iter == chg_at) sample_in = sample_t'(chg_val);
      if (i2s_bclk && !prev) begin
        if (rises < 32) begin
          left = {left[30:0], i2s_sdata};
          if (i2s_lrck) lr_err++;
        end else begin
          right = {right[30:0], i2s_sdata};
          if (!i2s_lrck) lr_err++;
        end
        rises++;
      end
      prev = i2s_bclk;
    end
    if (rises < 64) lr_err += 1000;
  endtask

  task automatic frame_check(input string name, input int chg_at, input logic [15:0] chg_val,
                             input logic [31:0] exp_word);
    logic [31:0] l, r;
    int e;
    collect_frame(chg_at, chg_val, l, r, e);
    check({name, "_left"},  l, exp_word);
    check({name, "_right"}, r, exp_word);
    check({name, "_lrck"},  32'(e), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sample_in = sample_t'(16'h8001);
    sound_on  = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_bclk",  32'(i2s_bclk),   32'd0);
    check("rst_lrck",  32'(i2s_lrck),   32'd1);
    check("rst_sdata", 32'(i2s_sdata),  32'd0);
    check("rst_req",   32'(sample_req), 32'd0);
    check("rst_mute",  32'(dac_mute),   32'd1);

    rst = 1'b0;
    cycles_to_req("first_capture_cycle", 4);
    check("mute_after_capture", 32'(dac_mute), 32'd0);
    frame_check("f8001", 0, 16'h0, 32'h4000_8000);
    wait_req();
    cycles_to_req("frame_period", 256);

    frame_check("f8001_hold", 40, 16'h1234, 32'h4000_8000);
    wait_req();
    frame_check("f1234", 0, 16'h0, 32'h091A_0000);

    sound_on  = 1'b0;
    sample_in = sample_t'(16'h7FC0);
    wait_req();
    check("muted_flag", 32'(dac_mute), 32'd1);
    frame_check("fmuted", 0, 16'h0, 32'h0000_0000);
    sound_on = 1'b1;
    wait_req();
    check("unmuted_flag", 32'(dac_mute), 32'd0);
    frame_check("f7fc0", 0, 16'h0, 32'h3FE0_0000);

    wait_req();
    repeat (160) @(negedge clk);
    check("bitcnt40_lrck", 32'(i2s_lrck), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bclk",  32'(i2s_bclk),   32'd0);
    check("midrst_lrck",  32'(i2s_lrck),   32'd1);
    check("midrst_sdata", 32'(i2s_sdata),  32'd0);
    check("midrst_req",   32'(sample_req), 32'd0);
    check("midrst_mute",  32'(dac_mute),   32'd1);
    rst = 1'b0;
    cycles_to_req("capture_after_rst", 4);

    for (int f = 0; f < 250; f++) begin
      logic [15:0] expv;
      logic [15:0] nv;
      if (f > 0) wait_req();
      expv = m_frame;
      nv   = 16'($urandom_range(0, 65535));
      frame_check("rand", int'($urandom_range(1, 250)), nv, {1'b0, expv, 15'b0});
      sound_on = ($urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
